// File: rtl/exe_stage_unit.sv
// Execute stage: ID/EX register, ALU, NZCV status register, branch target, EX/MEM register.
// Latency: a bundle sampled into ID/EX at edge k appears on ex_* after edge k+1.
// Backpressure: stall holds ID/EX, EX/MEM and status; flush bubbles ID/EX even while stalled.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   stall, flush          pipeline hold / bubble insert
//   id_*                  decoded instruction bundle from the ID stage
//   status                {N,Z,C,V}
//   branch_taken/addr     branch resolution from the instruction held in ID/EX
//   ex_*                  registered EX/MEM bundle towards the memory stage
// Optional feature (macro EXE_PERF_CNT_EN): perf_instr_cnt / perf_stall_cnt counters.

module exe_stage_unit #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [WIDTH-1:0]  id_pc,
    input  logic [3:0]        id_exe_cmd,
    input  logic              id_mem_read_en,
    input  logic              id_mem_write_en,
    input  logic              id_wb_en,
    input  logic              id_B,
    input  logic              id_S,
    input  logic [WIDTH-1:0]  id_val_rn,
    input  logic [WIDTH-1:0]  id_val2,
    input  logic [WIDTH-1:0]  id_val_rm,
    input  logic [REG_AW-1:0] id_dest,
    input  logic [23:0]       id_imm24,
    output logic [3:0]        status,
    output logic              branch_taken,
    output logic [WIDTH-1:0]  branch_addr,
    output logic              ex_valid,
    output logic              ex_wb_en,
    output logic              ex_mem_read_en,
    output logic              ex_mem_write_en,
    output logic [WIDTH-1:0]  ex_alu_res,
    output logic [WIDTH-1:0]  ex_val_rm,
    output logic [REG_AW-1:0] ex_dest
`ifdef EXE_PERF_CNT_EN
    ,
    output logic [31:0]       perf_instr_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    typedef struct packed {
        logic              valid;
        logic [WIDTH-1:0]  pc;
        logic [3:0]        cmd;
        logic              mem_read;
        logic              mem_write;
        logic              wb;
        logic              b;
        logic              s;
        logic [WIDTH-1:0]  val_rn;
        logic [WIDTH-1:0]  val2;
        logic [WIDTH-1:0]  val_rm;
        logic [REG_AW-1:0] dest;
        logic [23:0]       imm24;
    } idex_t;

    typedef struct packed {
        logic              valid;
        logic              wb;
        logic              mem_read;
        logic              mem_write;
        logic [WIDTH-1:0]  alu_res;
        logic [WIDTH-1:0]  val_rm;
        logic [REG_AW-1:0] dest;
    } exmem_t;

    idex_t      idex_q, idex_d;
    exmem_t     ex_q, ex_d;
    logic [3:0] status_q, status_d;

    // ---------------- ID/EX register: flush beats stall ----------------
    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d = '0;
        end else if (!stall) begin
            idex_d.valid     = id_valid;
            idex_d.pc        = id_pc;
            idex_d.cmd       = id_exe_cmd;
            idex_d.mem_read  = id_mem_read_en;
            idex_d.mem_write = id_mem_write_en;
            idex_d.wb        = id_wb_en;
            idex_d.b         = id_B;
            idex_d.s         = id_S;
            idex_d.val_rn    = id_val_rn;
            idex_d.val2      = id_val2;
            idex_d.val_rm    = id_val_rm;
            idex_d.dest      = id_dest;
            idex_d.imm24     = id_imm24;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    // ---------------- ALU ----------------
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] opb;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             alu_c, alu_v;
    logic             arith, cmd_ok;

    // Subtraction runs through the same adder as a + ~b + carry-in, so the
    // adder carry-out is directly the ARM "no borrow" C flag.
    always_comb begin
        alu_res = '0;
        opb     = idex_q.val2;
        cin     = 1'b0;
        sum     = '0;
        alu_c   = status_q[1];
        alu_v   = status_q[0];
        arith   = 1'b0;
        cmd_ok  = 1'b1;
        unique case (idex_q.cmd)
            CMD_MOV: alu_res = idex_q.val2;
            CMD_MVN: alu_res = ~idex_q.val2;
            CMD_ADD: arith = 1'b1;
            CMD_ADC: begin arith = 1'b1; cin = status_q[1]; end
            CMD_SUB: begin arith = 1'b1; opb = ~idex_q.val2; cin = 1'b1; end
            CMD_SBC: begin arith = 1'b1; opb = ~idex_q.val2; cin = status_q[1]; end
            CMD_AND: alu_res = idex_q.val_rn & idex_q.val2;
            CMD_ORR: alu_res = idex_q.val_rn | idex_q.val2;
            CMD_EOR: alu_res = idex_q.val_rn ^ idex_q.val2;
            default: cmd_ok = 1'b0;
        endcase
        if (arith) begin
            sum     = {1'b0, idex_q.val_rn} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (idex_q.val_rn[WIDTH-1] == opb[WIDTH-1]) &&
                      (sum[WIDTH-1] != idex_q.val_rn[WIDTH-1]);
        end
    end

    // ---------------- Status register ----------------
    logic status_we;
    assign status_we = idex_q.valid && idex_q.s && !idex_q.b && !idex_q.mem_read &&
                       !idex_q.mem_write && !stall && cmd_ok;

    always_comb begin
        status_d = status_q;
        if (status_we) begin
            status_d = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= 4'b0000;
        end else begin
            status_q <= status_d;
        end
    end

    // ---------------- Branch resolution ----------------
    logic [WIDTH-1:0] imm_sext;
    assign imm_sext     = {{(WIDTH-24){idex_q.imm24[23]}}, idex_q.imm24};
    assign branch_taken = idex_q.valid && idex_q.b;
    assign branch_addr  = idex_q.pc + (imm_sext << 2);

    // ---------------- EX/MEM register ----------------
    // Branches never write back or touch memory, whatever the decoder sent.
    always_comb begin
        ex_d = '0;
        if (idex_q.valid) begin
            ex_d.valid     = 1'b1;
            ex_d.wb        = idex_q.wb && !idex_q.b;
            ex_d.mem_read  = idex_q.mem_read && !idex_q.b;
            ex_d.mem_write = idex_q.mem_write && !idex_q.b;
            ex_d.alu_res   = alu_res;
            ex_d.val_rm    = idex_q.val_rm;
            ex_d.dest      = idex_q.dest;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else if (!stall) begin
            ex_q <= ex_d;
        end
    end

    assign status          = status_q;
    assign ex_valid        = ex_q.valid;
    assign ex_wb_en        = ex_q.wb;
    assign ex_mem_read_en  = ex_q.mem_read;
    assign ex_mem_write_en = ex_q.mem_write;
    assign ex_alu_res      = ex_q.alu_res;
    assign ex_val_rm       = ex_q.val_rm;
    assign ex_dest         = ex_q.dest;

`ifdef EXE_PERF_CNT_EN
    logic [31:0] perf_instr_cnt_q, perf_stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_instr_cnt_q <= '0;
            perf_stall_cnt_q <= '0;
        end else begin
            if (!stall && idex_q.valid) begin
                perf_instr_cnt_q <= perf_instr_cnt_q + 32'd1;
            end
            if (stall) begin
                perf_stall_cnt_q <= perf_stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_instr_cnt = perf_instr_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_exe_stage_unit.sv
// Bench for exe_stage_unit: directed scenarios then randomized traffic,
// every cycle compared against a behavioural model of the stage.
module tb_exe_stage_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        bit        valid;
        bit [31:0] pc;
        bit [3:0]  cmd;
        bit        mr;
        bit        mw;
        bit        wb;
        bit        b;
        bit        s;
        bit [31:0] rn;
        bit [31:0] v2;
        bit [31:0] rm;
        bit [3:0]  dest;
        bit [23:0] imm;
    } bnd_t;

    bnd_t drv;
    bit   drv_rst, drv_stall, drv_flush;

    logic        status_bt;
    logic [3:0]  status;
    logic [31:0] branch_addr, ex_alu_res, ex_val_rm;
    logic        ex_valid, ex_wb_en, ex_mem_read_en, ex_mem_write_en;
    logic [3:0]  ex_dest;
`ifdef EXE_PERF_CNT_EN
    logic [31:0] perf_instr_cnt, perf_stall_cnt;
`endif

    exe_stage_unit #(.WIDTH(32), .REG_AW(4)) dut (
        .clk             (clk),
        .rst             (drv_rst),
        .stall           (drv_stall),
        .flush           (drv_flush),
        .id_valid        (drv.valid),
        .id_pc           (drv.pc),
        .id_exe_cmd      (drv.cmd),
        .id_mem_read_en  (drv.mr),
        .id_mem_write_en (drv.mw),
        .id_wb_en        (drv.wb),
        .id_B            (drv.b),
        .id_S            (drv.s),
        .id_val_rn       (drv.rn),
        .id_val2         (drv.v2),
        .id_val_rm       (drv.rm),
        .id_dest         (drv.dest),
        .id_imm24        (drv.imm),
        .status          (status),
        .branch_taken    (status_bt),
        .branch_addr     (branch_addr),
        .ex_valid        (ex_valid),
        .ex_wb_en        (ex_wb_en),
        .ex_mem_read_en  (ex_mem_read_en),
        .ex_mem_write_en (ex_mem_write_en),
        .ex_alu_res      (ex_alu_res),
        .ex_val_rm       (ex_val_rm),
        .ex_dest         (ex_dest)
`ifdef EXE_PERF_CNT_EN
        ,
        .perf_instr_cnt  (perf_instr_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- behavioural model ----------------
    bnd_t      m_idex;
    bit        me_valid, me_wb, me_mr, me_mw;
    bit [31:0] me_res, me_rm;
    bit [3:0]  me_dest;
    bit [3:0]  m_status;
`ifdef EXE_PERF_CNT_EN
    bit [31:0] m_pi, m_ps;
`endif

    localparam longint SMAX = 64'sh7FFFFFFF;
    localparam longint SMIN = -64'sh80000000;

    function automatic void alu_ref(input bit [3:0] cmd, input bit [31:0] a, input bit [31:0] b,
                                    input bit [3:0] st, output bit [31:0] res,
                                    output bit [3:0] nzcv, output bit upd);
        longint unsigned ua, ub, full;
        longint sa, sb, sfull;
        bit c, v, extra;
        ua = a; ub = b;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c = st[1]; v = st[0]; upd = 1'b1; res = '0;
        case (cmd)
            4'd1: res = b;
            4'd9: res = ~b;
            4'd2, 4'd3: begin
                extra = (cmd == 4'd3) ? st[1] : 1'b0;
                full  = ua + ub + extra;
                res   = full[31:0];
                c     = full > 64'hFFFFFFFF;
                sfull = sa + sb + extra;
                v     = (sfull > SMAX) || (sfull < SMIN);
            end
            4'd4, 4'd5: begin
                extra = (cmd == 4'd5) ? !st[1] : 1'b0;   // borrow in
                res   = a - b - extra;
                c     = ua >= (ub + extra);
                sfull = sa - sb - extra;
                v     = (sfull > SMAX) || (sfull < SMIN);
            end
            4'd6: res = a & b;
            4'd7: res = a | b;
            4'd8: res = a ^ b;
            default: upd = 1'b0;
        endcase
        nzcv = {res[31], res == 0, c, v};
    endfunction

    task automatic model_edge();
        bit [31:0] r;
        bit [3:0]  f;
        bit        u;
        if (drv_rst) begin
            m_idex = '0;
            {me_valid, me_wb, me_mr, me_mw} = '0;
            me_res = '0; me_rm = '0; me_dest = '0;
            m_status = '0;
`ifdef EXE_PERF_CNT_EN
            m_pi = 0; m_ps = 0;
`endif
        end else begin
`ifdef EXE_PERF_CNT_EN
            if (drv_stall) m_ps++;
            else if (m_idex.valid) m_pi++;
`endif
            if (!drv_stall) begin
                if (m_idex.valid) begin
                    alu_ref(m_idex.cmd, m_idex.rn, m_idex.v2, m_status, r, f, u);
                    me_valid = 1'b1;
                    me_wb    = m_idex.wb && !m_idex.b;
                    me_mr    = m_idex.mr && !m_idex.b;
                    me_mw    = m_idex.mw && !m_idex.b;
                    me_res   = r;
                    me_rm    = m_idex.rm;
                    me_dest  = m_idex.dest;
                    if (m_idex.s && !m_idex.b && !m_idex.mr && !m_idex.mw && u) m_status = f;
                end else begin
                    {me_valid, me_wb, me_mr, me_mw} = '0;
                end
            end
            if (drv_flush) m_idex = '0;
            else if (!drv_stall) m_idex = drv;
        end
    endtask

    task automatic compare_all();
        bit [31:0] target;
        check("status", status, m_status);
        check("branch_taken", status_bt, m_idex.valid && m_idex.b);
        if (m_idex.valid && m_idex.b) begin
            target = m_idex.pc + 32'(longint'($signed(m_idex.imm)) * 4);
            check("branch_addr", branch_addr, target);
        end
        check("ex_valid", ex_valid, me_valid);
        check("ex_wb_en", ex_wb_en, me_wb);
        check("ex_mem_read_en", ex_mem_read_en, me_mr);
        check("ex_mem_write_en", ex_mem_write_en, me_mw);
        if (me_valid) begin
            check("ex_alu_res", ex_alu_res, me_res);
            check("ex_val_rm", ex_val_rm, me_rm);
            check("ex_dest", ex_dest, me_dest);
        end
`ifdef EXE_PERF_CNT_EN
        check("perf_instr_cnt", perf_instr_cnt, m_pi);
        check("perf_stall_cnt", perf_stall_cnt, m_ps);
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    function automatic bnd_t mk(input bit [3:0] cmd, input bit [31:0] rn, input bit [31:0] v2, input bit s);
        bnd_t x;
        x       = '0;
        x.valid = 1'b1;
        x.wb    = 1'b1;
        x.cmd   = cmd;
        x.rn    = rn;
        x.v2    = v2;
        x.s     = s;
        x.pc    = $urandom;
        x.rm    = $urandom;
        x.dest  = 4'($urandom_range(0, 15));
        return x;
    endfunction

    function automatic bit [31:0] pick_op();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        drv = '0; drv_rst = 1'b1; drv_stall = 1'b0; drv_flush = 1'b0;
        cyc(); cyc();
        check("rst_status", status, 4'b0000);
        check("rst_branch", status_bt, 1'b0);
        check("rst_ex_valid", ex_valid, 1'b0);
        drv_rst = 1'b0;

        // ADD 7+5 with S
        drv = mk(4'd2, 32'd7, 32'd5, 1'b1); cyc();
        drv = '0; cyc();
        check("t1_res", ex_alu_res, 32'd12);
        check("t1_wb", ex_wb_en, 1'b1);
        check("t1_nzcv", status, 4'b0000);

        // SUB 3-5 then ADC 0+0 using the fresh C
        drv = mk(4'd4, 32'd3, 32'd5, 1'b1); cyc();
        drv = mk(4'd3, 32'd0, 32'd0, 1'b1); cyc();
        check("t2_sub_res", ex_alu_res, 32'hFFFF_FFFE);
        check("t2_sub_nzcv", status, 4'b1000);
        drv = '0; cyc();
        check("t2_adc_res", ex_alu_res, 32'd0);
        check("t2_adc_nzcv", status, 4'b0100);

        // signed overflow, then a test-only AND keeps C,V
        drv = mk(4'd2, 32'h7FFF_FFFF, 32'd1, 1'b1); cyc();
        drv = mk(4'd6, 32'd0, 32'd0, 1'b1); drv.wb = 1'b0; cyc();
        check("t3_add_res", ex_alu_res, 32'h8000_0000);
        check("t3_add_nzcv", status, 4'b1001);
        drv = '0; cyc();
        check("t3_tst_nzcv", status, 4'b0101);

        // branch with negative offset, then flush
        drv = mk(4'd2, 32'd0, 32'd0, 1'b0); drv.b = 1'b1; drv.pc = 32'h100; drv.imm = 24'hFFFFFE;
        cyc();
        check("t4_taken", status_bt, 1'b1);
        check("t4_addr", branch_addr, 32'h0000_00F8);
        drv = mk(4'd1, 32'd0, 32'd9, 1'b0); drv_flush = 1'b1; cyc();
        check("t4_flushed", status_bt, 1'b0);
        check("t4_br_ex_valid", ex_valid, 1'b1);
        check("t4_br_ex_wb", ex_wb_en, 1'b0);
        drv_flush = 1'b0; drv = '0; cyc();

        // stall three cycles, then stall+flush
        drv = mk(4'd2, 32'd10, 32'd20, 1'b1); cyc();
        drv = mk(4'd1, 32'd0, 32'd1, 1'b1); cyc();
        check("t5_res", ex_alu_res, 32'd30);
        drv_stall = 1'b1;
        drv = mk(4'd8, 32'hAAAA_0000, 32'h0000_5555, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t5_hold_res", ex_alu_res, 32'd30);
            check("t5_hold_nzcv", status, 4'b0000);
        end
        drv_flush = 1'b1; cyc();
        check("t5_sf_res", ex_alu_res, 32'd30);
        drv_flush = 1'b0; drv_stall = 1'b0; drv = '0; cyc();
        check("t5_bubble", ex_valid, 1'b0);

        // LDR with S set leaves status alone
        drv = mk(4'd4, 32'd3, 32'd5, 1'b1); cyc();
        drv = mk(4'd2, 32'h20, 32'd4, 1'b1); drv.mr = 1'b1; cyc();
        drv = '0; cyc();
        check("t6_addr", ex_alu_res, 32'h24);
        check("t6_mr", ex_mem_read_en, 1'b1);
        check("t6_nzcv", status, 4'b1000);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            drv       = mk(4'($urandom_range(0, 15)), pick_op(), pick_op(), 1'($urandom_range(0, 1)));
            drv.valid = ($urandom_range(0, 9) < 8);
            drv.wb    = 1'($urandom_range(0, 1));
            drv.mr    = ($urandom_range(0, 9) < 2);
            drv.mw    = ($urandom_range(0, 9) < 2);
            drv.b     = ($urandom_range(0, 9) < 2);
            drv.imm   = 24'($urandom);
            drv_stall = ($urandom_range(0, 9) < 2);
            drv_flush = ($urandom_range(0, 9) < 1);
            drv_rst   = ($urandom_range(0, 99) < 2);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
